// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and bit-period arithmetic.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BRK
   } rx_state_t;

   // Clocks per bit, identical to the transmitter so both ends agree on timing.
   function automatic int bit_period(input int freq, input int rate);
      return freq / rate;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing asynchronous inputs into the clock domain.
module sync_2ff #(
   parameter int               Width      = 1,
   parameter logic [Width-1:0] ResetValue = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [Width-1:0] d,
   output logic [Width-1:0] q
);

   logic [Width-1:0] meta;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta <= ResetValue;
         q    <= ResetValue;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and one-cycle valid/ferr strobes.
// Defining UART_RX_PARITY_EN switches the frame to 8E1 and adds the perr output.
module uart_rx
   import uart_pkg::*;
#(
   parameter int Clock = 50000000,
   parameter int Baud  = 9600
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rxen,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 ferr,
`ifdef UART_RX_PARITY_EN
   output logic                 perr,
`endif
   output logic                 busy
);

   localparam int T = bit_period(Clock, Baud);
   localparam int Q = $clog2(T + 1);
   localparam logic [Q-1:0] TimerLast = Q'(T - 1);
   localparam logic [Q-1:0] TimerHalf = Q'(T / 2 - 1);
   localparam logic [2:0]   IndexLast = 3'(DATA_BITS - 1);

   if (T < 4) begin : g_period_check
      $error("uart_rx: Clock/Baud must give at least 4 clocks per bit");
   end

   rx_state_t            state, stateNext;
   logic [Q-1:0]         timer, timerNext;
   logic [2:0]           index, indexNext;
   logic [DATA_BITS-1:0] shift, shiftNext;
   logic [DATA_BITS-1:0] dataNext;
   logic                 validNext, ferrNext;
   logic                 rxs;
`ifdef UART_RX_PARITY_EN
   logic                 pflag, pflagNext, perrNext;
`endif

   // Line idles high, so the synchronizer resets to 1 to avoid a false start.
   sync_2ff #(.Width(1), .ResetValue(1'b1)) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (rxd),
      .q     (rxs)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         timer <= '0;
         index <= '0;
         shift <= '0;
         data  <= '0;
         valid <= 1'b0;
         ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         pflag <= 1'b0;
         perr  <= 1'b0;
`endif
      end else begin
         state <= stateNext;
         timer <= timerNext;
         index <= indexNext;
         shift <= shiftNext;
         data  <= dataNext;
         valid <= validNext;
         ferr  <= ferrNext;
`ifdef UART_RX_PARITY_EN
         pflag <= pflagNext;
         perr  <= perrNext;
`endif
      end
   end

   always_comb begin
      stateNext = state;
      timerNext = timer;
      indexNext = index;
      shiftNext = shift;
      dataNext  = data;
      validNext = 1'b0;
      ferrNext  = 1'b0;
`ifdef UART_RX_PARITY_EN
      pflagNext = pflag;
      perrNext  = 1'b0;
`endif
      if (!rxen) begin
         stateNext = IDLE;
         timerNext = '0;
         indexNext = '0;
      end else begin
         unique case (state)
            IDLE: begin
               timerNext = '0;
               if (!rxs) stateNext = START;
            end
            // Half a bit in, a still-low line confirms a real start bit.
            START: begin
               if (timer == TimerHalf) begin
                  timerNext = '0;
                  indexNext = '0;
                  stateNext = rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                  pflagNext = 1'b0;
`endif
               end else begin
                  timerNext = timer + 1'b1;
               end
            end
            DATA: begin
               if (timer == TimerLast) begin
                  timerNext        = '0;
                  shiftNext[index] = rxs;
                  if (index == IndexLast) begin
                     indexNext = '0;
`ifdef UART_RX_PARITY_EN
                     stateNext = PARITY;
`else
                     stateNext = STOP;
`endif
                  end else begin
                     indexNext = index + 3'd1;
                  end
               end else begin
                  timerNext = timer + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (timer == TimerLast) begin
                  timerNext = '0;
                  pflagNext = rxs ^ (^shift);
                  stateNext = STOP;
               end else begin
                  timerNext = timer + 1'b1;
               end
            end
`endif
            STOP: begin
               if (timer == TimerLast) begin
                  timerNext = '0;
                  if (rxs) begin
                     stateNext = IDLE;
`ifdef UART_RX_PARITY_EN
                     if (pflag) begin
                        perrNext = 1'b1;
                     end else begin
                        dataNext  = shift;
                        validNext = 1'b1;
                     end
`else
                     dataNext  = shift;
                     validNext = 1'b1;
`endif
                  end else begin
                     ferrNext  = 1'b1;
                     stateNext = BRK;
                  end
               end else begin
                  timerNext = timer + 1'b1;
               end
            end
            // Hold off until the line recovers so a break cannot retrigger.
            BRK: begin
               timerNext = '0;
               if (rxs) stateNext = IDLE;
            end
            default: begin
               stateNext = IDLE;
               timerNext = '0;
               indexNext = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at T=16 clocks per bit; expected strobes are queued by the stimulus.
module tb_uart_rx;

   localparam int T = 16;
`ifdef UART_RX_PARITY_EN
   localparam int Latency = 2 + T / 2 + 10 * T;
`else
   localparam int Latency = 2 + T / 2 + 9 * T;
`endif

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         start;
      bit         checkLat;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       rxen;
   logic       rxd;
   logic [7:0] data;
   logic       valid;
   logic       ferr;
   logic       busy;
   logic       perr;

   exp_t       expq[$];
   logic [7:0] lastGood;
   int         cycle = 0;
   int         compared = 0;
   int         mismatched = 0;

   uart_rx #(.Clock(160), .Baud(10)) dut (
      .clock (clock),
      .reset (reset),
      .rxen  (rxen),
      .rxd   (rxd),
      .data  (data),
      .valid (valid),
      .ferr  (ferr),
`ifdef UART_RX_PARITY_EN
      .perr  (perr),
`endif
      .busy  (busy)
   );

`ifndef UART_RX_PARITY_EN
   assign perr = 1'b0;
`endif

   always #5 clock = ~clock;

   always @(posedge clock) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input int actual, input int expected, input int tol = 0);
      compared++;
      if (actual < expected - tol || actual > expected + tol) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (tolerance %0d) at cycle %0d",
                  name, actual, expected, tol, cycle);
      end
   endtask

   task automatic waitClocks(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic sendFrame(input logic [7:0] b, input logic stopBit, input logic badParity);
      rxd = 1'b0;
      waitClocks(T);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         waitClocks(T);
      end
`ifdef UART_RX_PARITY_EN
      rxd = (^b) ^ badParity;
      waitClocks(T);
`endif
      rxd = stopBit;
      waitClocks(T);
   endtask

   // kind: 0 = valid, 1 = ferr, 2 = perr; the model tracks the last good byte.
   task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input logic badParity);
      exp_t e;
      e.start    = cycle;
      e.checkLat = 1'b1;
      if (!stopBit) begin
         e.kind = 1;
         e.data = lastGood;
      end else if (badParity) begin
         e.kind = 2;
         e.data = lastGood;
      end else begin
         e.kind   = 0;
         e.data   = b;
         lastGood = b;
      end
      expq.push_back(e);
      sendFrame(b, stopBit, badParity);
   endtask

   // Monitor: every strobe must match the head of the expectation queue.
   always @(posedge clock) begin
      exp_t e;
      int   kind;
      #1;
      if (reset && (valid || ferr || perr)) begin
         if (valid && ferr)
            checkOutput("valid_ferr_exclusive", 1, 0);
         kind = ferr ? 1 : (valid ? 0 : 2);
         if (expq.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_strobe: got kind %0d data %0h, expected no strobe", kind, data);
         end else begin
            e = expq.pop_front();
            checkOutput("strobe_kind", kind, e.kind);
            checkOutput("strobe_data", int'(data), int'(e.data));
            if (e.checkLat)
               checkOutput("strobe_latency", cycle - e.start, Latency, 1);
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset    = 1'b0;
      rxen     = 1'b1;
      rxd      = 1'b1;
      lastGood = 8'h00;
      waitClocks(3);
      checkOutput("reset_data", int'(data), 0);
      checkOutput("reset_valid", int'(valid), 0);
      checkOutput("reset_ferr", int'(ferr), 0);
      checkOutput("reset_busy", int'(busy), 0);
      reset = 1'b1;
      waitClocks(10);

      $display("[TB] single frame 0xA5");
      applyStimulus(8'hA5, 1'b1, 1'b0);
      waitClocks(20);

      $display("[TB] back-to-back 0x00 0xFF 0x55");
      applyStimulus(8'h00, 1'b1, 1'b0);
      applyStimulus(8'hFF, 1'b1, 1'b0);
      applyStimulus(8'h55, 1'b1, 1'b0);
      waitClocks(20);

      $display("[TB] 4-clock glitch");
      rxd = 1'b0;
      waitClocks(4);
      rxd = 1'b1;
      checkOutput("glitch_busy_high", int'(busy), 1);
      waitClocks(12);
      checkOutput("glitch_busy_low", int'(busy), 0);
      waitClocks(20);

      $display("[TB] framing error 0x3C with break");
      applyStimulus(8'h3C, 1'b0, 1'b0);
      waitClocks(24);
      checkOutput("break_busy_high", int'(busy), 1);
      rxd = 1'b1;
      waitClocks(6);
      checkOutput("break_busy_low", int'(busy), 0);
      waitClocks(20);

      $display("[TB] rxen dropped mid-frame of 0x81");
      rxd = 1'b0;
      waitClocks(T);
      for (int i = 0; i < 4; i++) begin
         rxd = (i == 0);
         waitClocks(T);
      end
      rxd = 1'b0;
      waitClocks(8);
      checkOutput("rxen_busy_before", int'(busy), 1);
      rxen = 1'b0;
      @(posedge clock);
      #1;
      checkOutput("rxen_busy_after", int'(busy), 0);
      rxd = 1'b1;
      waitClocks(40);
      rxen = 1'b1;
      waitClocks(20);
      applyStimulus(8'h81, 1'b1, 1'b0);
      waitClocks(20);

      $display("[TB] async reset mid-frame");
      rxd = 1'b0;
      waitClocks(40);
      @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      checkOutput("midreset_data", int'(data), 0);
      checkOutput("midreset_valid", int'(valid), 0);
      checkOutput("midreset_ferr", int'(ferr), 0);
      checkOutput("midreset_busy", int'(busy), 0);
      lastGood = 8'h00;
      rxd = 1'b1;
      waitClocks(5);
      reset = 1'b1;
      waitClocks(20);
      applyStimulus(8'h7E, 1'b1, 1'b0);
      waitClocks(20);

`ifdef UART_RX_PARITY_EN
      $display("[TB] parity error 0x07");
      applyStimulus(8'h07, 1'b1, 1'b1);
      waitClocks(20);
`endif

      waitClocks(50);
      checkOutput("queue_drained", expq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
